// File: rtl/lsu_axi_master.sv
// LSU initiator: one load/store at a time onto AXI-lite AR/R/AW/W/B.
// Handles lane alignment, strobes, load extension and misalignment errors.
module lsu_axi_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        off_q, off_d;
  logic [2:0]        type_q, type_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              req_ready_d;
  logic              resp_valid_d;
  logic [31:0]       resp_rdata_d;
  logic              resp_err_d;
  logic [ADDR_W-1:0] araddr_d;
  logic              arvalid_d;
  logic              rready_d;
  logic [ADDR_W-1:0] awaddr_d;
  logic              awvalid_d;
  logic [31:0]       wdata_d;
  logic [3:0]        wstrb_d;
  logic              wvalid_d;
  logic              bready_d;

  logic              bad;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ext_v;
  logic              aw_n;
  logic              w_n;

  always_comb begin
    bad = 1'b0;
    if (req_wen) begin
      bad = (req_type > 3'd2)
          | ((req_type == 3'd1) & req_addr[0])
          | ((req_type == 3'd2) & (req_addr[1:0] != 2'b00));
    end else begin
      bad = (req_type > 3'd4)
          | (((req_type == 3'd1) | (req_type == 3'd4)) & req_addr[0])
          | ((req_type == 3'd2) & (req_addr[1:0] != 2'b00));
    end
  end

  always_comb begin
    byte_v = rdata[8*off_q +: 8];
    half_v = rdata[16*off_q[1] +: 16];
    ext_v  = 32'h0;
    unique case (1'b1)
      type_q == 3'd0: ext_v = {{24{byte_v[7]}}, byte_v};
      type_q == 3'd1: ext_v = {{16{half_v[15]}}, half_v};
      type_q == 3'd2: ext_v = rdata;
      type_q == 3'd3: ext_v = {24'h0, byte_v};
      type_q == 3'd4: ext_v = {16'h0, half_v};
      default:        ext_v = 32'h0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    type_d       = type_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    req_ready_d  = req_ready;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    araddr_d     = araddr;
    arvalid_d    = arvalid;
    rready_d     = rready;
    awaddr_d     = awaddr;
    awvalid_d    = awvalid;
    wdata_d      = wdata;
    wstrb_d      = wstrb;
    wvalid_d     = wvalid;
    bready_d     = bready;
    aw_n         = aw_done_q | (awvalid & awready);
    w_n          = w_done_q | (wvalid & wready);

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_d = 1'b0;
          off_d       = req_addr[1:0];
          type_d      = req_type;
          if (bad) begin
            state_d = ERR;
          end else if (req_wen) begin
            state_d   = WR_REQ;
            awaddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            unique case (1'b1)
              req_type == 3'd0: begin
                wdata_d = {4{req_wdata[7:0]}};
                wstrb_d = 4'b0001 << req_addr[1:0];
              end
              req_type == 3'd1: begin
                wdata_d = {2{req_wdata[15:0]}};
                wstrb_d = 4'b0011 << req_addr[1:0];
              end
              default: begin
                wdata_d = req_wdata;
                wstrb_d = 4'hF;
              end
            endcase
          end else begin
            state_d   = RD_ADDR;
            araddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            arvalid_d = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rready_d     = 1'b0;
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = rresp;
          resp_rdata_d = rresp ? 32'h0 : ext_v;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; both may finish together.
        if (aw_n) awvalid_d = 1'b0;
        if (w_n)  wvalid_d  = 1'b0;
        aw_done_d = aw_n;
        w_done_d  = w_n;
        if (aw_n && w_n) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d     = 1'b0;
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = bresp;
          resp_rdata_d = 32'h0;
        end
      end
      ERR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = 32'h0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      off_q      <= 2'b00;
      type_q     <= 3'd0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= 32'h0;
      wstrb      <= 4'h0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      type_q     <= type_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      araddr     <= araddr_d;
      arvalid    <= arvalid_d;
      rready     <= rready_d;
      awaddr     <= awaddr_d;
      awvalid    <= awvalid_d;
      wdata      <= wdata_d;
      wstrb      <= wstrb_d;
      wvalid     <= wvalid_d;
      bready     <= bready_d;
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a response scoreboard.
// Inputs change 1 time unit after posedge; monitors sample on negedge.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;

  lsu_axi_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_type(req_type), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          tests  = 0;
  int          failed = 0;
  int          cyc    = 0;
  int          resp_cnt = 0;
  int          ar_cnt = 0;
  int          acc_cyc = 0;
  int          resp_cyc = 0;
  logic [31:0] last_araddr = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (arvalid) ar_cnt++;
      if (arvalid && arready) last_araddr = araddr;
      if (resp_valid) begin
        exp_t e;
        resp_cnt++;
        resp_cyc = cyc;
        check("ready_low_in_resp", {31'h0, req_ready}, 32'h0);
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 32'h1, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] a,
                       input logic [2:0] t, input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = a;
    req_type  = t;
    req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int c0);
    int n = 0;
    while (resp_cnt == c0 && n < 20) begin
      tick();
      n++;
    end
    check("resp_seen", resp_cnt, c0 + 1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] t,
                         input logic [31:0] rd, input logic rr,
                         input int r_wait, input logic [31:0] exp_d);
    int   n;
    int   c0;
    exp_t e;
    e.rdata = exp_d;
    e.err   = rr;
    sb_q.push_back(e);
    c0 = resp_cnt;
    issue(1'b0, a, t, 32'h0);
    arready = 1'b1;
    n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    tick();
    arready = 1'b0;
    repeat (r_wait) tick();
    rvalid = 1'b1;
    rdata  = rd;
    rresp  = rr;
    n = 0;
    while (!rready && n < 20) begin
      tick();
      n++;
    end
    tick();
    rvalid = 1'b0;
    wait_resp(c0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] wd, input int aw_wait,
                          input int w_wait, input logic br,
                          output logic [31:0] got_awaddr,
                          output logic [31:0] got_wdata,
                          output logic [3:0] got_wstrb,
                          output int aw_hi, output int w_hi);
    int   n;
    int   k;
    int   c0;
    logic awd;
    logic wd_done;
    logic hs_aw;
    logic hs_w;
    exp_t e;
    e.rdata = 32'h0;
    e.err   = br;
    sb_q.push_back(e);
    c0 = resp_cnt;
    aw_hi = 0;
    w_hi  = 0;
    got_awaddr = 32'hx;
    got_wdata  = 32'hx;
    got_wstrb  = 4'hx;
    issue(1'b1, a, t, wd);
    awd = 1'b0;
    wd_done = 1'b0;
    k = 0;
    while (!(awd && wd_done) && k < 20) begin
      awready = (k >= aw_wait) && !awd;
      wready  = (k >= w_wait) && !wd_done;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (hs_aw) got_awaddr = awaddr;
      if (hs_w) begin
        got_wdata = wdata;
        got_wstrb = wstrb;
      end
      tick();
      if (hs_aw) awd = 1'b1;
      if (hs_w) wd_done = 1'b1;
      k++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b1;
    bresp   = br;
    n = 0;
    while (!bready && n < 20) begin
      tick();
      n++;
    end
    tick();
    bvalid = 1'b0;
    bresp  = 1'b0;
    wait_resp(c0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ga;
    logic [31:0] gd;
    logic [3:0]  gs;
    int          ah;
    int          wh;
    int          c0;
    int          a0;

    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
    req_type = 3'd0; req_wdata = 32'h0;
    arready = 1'b0; rdata = 32'h0; rresp = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 1'b0; bvalid = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_valids",
          {25'h0, arvalid, rready, awvalid, wvalid, bready,
           resp_valid, resp_err}, 32'h0);
    check("rst_data", resp_rdata | araddr | awaddr | wdata, 32'h0);
    check("rst_wstrb", {28'h0, wstrb}, 32'h0);
    rst = 1'b0;
    tick();

    do_load(32'h8000_0004, 3'd2, 32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF);
    check("lw_araddr", last_araddr, 32'h8000_0004);
    repeat (3) tick();
    check("rdata_hold", resp_rdata, 32'hDEAD_BEEF);

    do_load(32'h8000_0003, 3'd0, 32'h80FF_1234, 1'b0, 0, 32'hFFFF_FF80);
    check("lb_araddr", last_araddr, 32'h8000_0000);
    check("load_latency", resp_cyc - acc_cyc, 3);
    do_load(32'h8000_0003, 3'd3, 32'h80FF_1234, 1'b0, 0, 32'h0000_0080);
    do_load(32'h8000_0002, 3'd1, 32'h80FF_1234, 1'b0, 1, 32'hFFFF_80FF);
    do_load(32'h8000_0002, 3'd4, 32'h80FF_1234, 1'b0, 0, 32'h0000_80FF);
    do_load(32'h8000_0008, 3'd2, 32'h1234_5678, 1'b1, 0, 32'h0);

    do_store(32'h1000_0002, 3'd1, 32'h0000_ABCD, 0, 1, 1'b0,
             ga, gd, gs, ah, wh);
    check("sh_awaddr", ga, 32'h1000_0000);
    check("sh_wdata", gd, 32'hABCD_ABCD);
    check("sh_wstrb", {28'h0, gs}, 32'hC);
    check("sh_aw_cycles", ah, 1);
    check("sh_w_cycles", wh, 2);

    do_store(32'h1000_0001, 3'd0, 32'h0000_005A, 0, 0, 1'b0,
             ga, gd, gs, ah, wh);
    check("sb_wdata", gd, 32'h5A5A_5A5A);
    check("sb_wstrb", {28'h0, gs}, 32'h2);
    check("sb_aw_cycles", ah, 1);
    check("sb_w_cycles", wh, 1);
    check("store_latency", resp_cyc - acc_cyc, 3);

    do_store(32'h1000_0010, 3'd2, 32'hCAFE_F00D, 1, 0, 1'b1,
             ga, gd, gs, ah, wh);
    check("sw_wdata", gd, 32'hCAFE_F00D);
    check("sw_wstrb", {28'h0, gs}, 32'hF);

    begin
      exp_t e;
      e.rdata = 32'h0;
      e.err   = 1'b1;
      sb_q.push_back(e);
      c0 = resp_cnt;
      a0 = ar_cnt;
      rvalid = 1'b1;
      bvalid = 1'b1;
      issue(1'b0, 32'h8000_0002, 3'd2, 32'h0);
      wait_resp(c0);
      rvalid = 1'b0;
      bvalid = 1'b0;
      check("misalign_no_ar", ar_cnt, a0);
      check("misalign_latency", resp_cyc - acc_cyc, 2);
      sb_q.push_back(e);
      c0 = resp_cnt;
      issue(1'b1, 32'h1000_0000, 3'd3, 32'h0);
      wait_resp(c0);
    end

    c0 = resp_cnt;
    issue(1'b0, 32'h8000_0010, 3'd2, 32'h0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("pre_rst_rready", {31'h0, rready}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_rready", {31'h0, rready}, 32'h0);
    check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (5) tick();
    check("post_rst_no_resp", resp_cnt, c0);

    do_load(32'h8000_0001, 3'd3, 32'h1122_3344, 1'b0, 0, 32'h0000_0033);
    repeat (3) tick();
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Initiator side of the LSU memory interface.
- Accepts one load or store request at a time from the MEM stage and drives the AXI-lite style AR/R/AW/W/B channels toward the data SRAM responder.
- Performs byte-lane alignment, write-strobe generation and load sign/zero extension internally.
- Returns a single-cycle completion pulse to the pipeline, which stalls on req_ready.

Parameters:
ADDR_W, 32, width of request and bus addresses (data width fixed at 32)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  pipeline memory request present
req_ready  output  1  block idle, request accepted this cycle if req_valid
req_wen  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  byte address
req_type  input  3  load: 0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu; store: 0 sb, 1 sh, 2 sw
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data, valid with resp_valid
resp_err  output  1  misaligned, illegal type, or bus error; valid with resp_valid
araddr  output  ADDR_W  read address, word-aligned
arvalid  output  1  read address valid
arready  input  1  responder accepts read address
rdata  input  32  read data word
rresp  input  1  read error when 1
rvalid  input  1  read data valid
rready  output  1  master accepts read data
awaddr  output  ADDR_W  write address, word-aligned
awvalid  output  1  write address valid
awready  input  1  responder accepts write address
wdata  output  32  lane-replicated write data
wstrb  output  4  byte enables
wvalid  output  1  write data valid
wready  input  1  responder accepts write data
bresp  input  1  write error when 1
bvalid  input  1  write response valid
bready  output  1  master accepts write response

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, ERR.
- All outputs are registered.
- Reset values: state IDLE; req_ready=1; arvalid, rready, awvalid, wvalid, bready, resp_valid and resp_err=0; resp_rdata, araddr, awaddr, wdata and wstrb=0.
- req_ready=1 only in IDLE and never in the cycle resp_valid is high.
- Accept (req_valid & req_ready): latch addr, type, wen and the low address bits.
- Misalignment: half-word with addr[0]=1, word with addr[1:0]!=0, store type >2, or load type >4 go to ERR.
- ERR: the next cycle emits resp_valid=1, resp_err=1, resp_rdata=0, then returns to IDLE. No bus activity occurs.
- Load accept: next cycle arvalid=1, araddr={addr[ADDR_W-1:2],2'b00}, state RD_ADDR.
- RD_ADDR: hold arvalid and araddr until arvalid&arready. In that cycle's edge drop arvalid, raise rready, go to RD_DATA.
- RD_DATA: on rvalid&rready, drop rready and go to IDLE. The next cycle has resp_valid=1.
  - Extraction with off=addr[1:0]: byte = rdata[8*off+:8]; half = rdata[16*addr[1]+:16].
  - Types 0/1 sign-extend, 3/4 zero-extend, 2 passes through.
  - resp_err=rresp; if rresp=1, resp_rdata=0.
- Store accept: next cycle awvalid=1 and wvalid=1 together, state WR_REQ.
  - awaddr is word-aligned.
  - sb: wdata={4{b}}, wstrb=4'b0001<<off.
  - sh: wdata={2{h}}, wstrb=4'b0011<<off.
  - sw: wdata=req_wdata, wstrb=4'hF.
- WR_REQ: each of awvalid and wvalid drops independently after its own handshake, tracked by aw_done and w_done flags.
  - A simultaneous handshake of both completes in one cycle.
  - Once both are done, raise bready and go to WR_RESP.
  - Address, data and strobe stay stable while the corresponding valid is high.
- WR_RESP: on bvalid&bready, drop bready and go to IDLE. The next cycle has resp_valid=1, resp_err=bresp, resp_rdata=0.
- resp_valid is exactly one cycle. resp_rdata and resp_err hold their value until the next response.
- Minimum latency with a zero-wait responder: load = accept + 3 cycles to resp_valid; store = accept + 3 cycles.
- rvalid or bvalid arriving in any state other than RD_DATA or WR_RESP is ignored.
- Reset mid-transaction: all valid/ready outputs drop the next cycle and state returns to IDLE. The in-flight transfer is abandoned and no resp_valid is produced.

Test Plan:
- Load lw addr 0x80000004, responder returns rdata=0xDEADBEEF after 2 wait cycles -> araddr=0x80000004, one resp_valid, resp_rdata=0xDEADBEEF, resp_err=0.
- Load lb addr 0x80000003 with rdata=0x80FF1234, then lbu at the same address -> resp_rdata=0xFFFFFF80, then 0x00000080; lh at 0x80000002 -> 0xFFFF80FF.
- Store sh addr 0x10000002, req_wdata=0x0000ABCD, awready one cycle before wready -> awvalid drops first, wdata=0xABCDABCD, wstrb=4'b1100, resp_valid after bvalid.
- Store sb addr 0x10000001, data 0x5A, awready and wready in the same cycle -> wstrb=4'b0010, wdata=0x5A5A5A5A, single-cycle WR_REQ.
- lw at addr 0x80000002 -> no arvalid ever, resp_valid with resp_err=1 two cycles after accept; a store with rresp/bresp=1 -> resp_err=1.
- Assert rst while in RD_DATA -> next cycle rready=0, req_ready=1, no resp_valid; a fresh load then completes normally.
